// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   alu_op_t    : 4-bit opcode (decoder and ALU agree on these encodings)
//   alu_ovr_t   : operand override select {NONE, IMM, IMM_HIGH}
//   alu_state_t : control FSM states (MUL/DIV/DONE only used with ALU_MULDIV_EN)
//   alu_flags_t : registered V/C/N/Z/X flag bundle
package alu_pkg;

  localparam int ALU_OP_W  = 4;
  localparam int ALU_OVR_W = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_NOT  = 4'h0, OP_AND  = 4'h1, OP_OR   = 4'h2, OP_XOR  = 4'h3,
    OP_ADD  = 4'h4, OP_SUB  = 4'h5, OP_MOV  = 4'h6, OP_CMP  = 4'h7,
    OP_SHR  = 4'h8, OP_SSHR = 4'h9, OP_SHL  = 4'hA, OP_MUL  = 4'hB,
    OP_MULH = 4'hC, OP_DIVU = 4'hD, OP_REMU = 4'hE, OP_ADC  = 4'hF
  } alu_op_t;

  typedef enum logic [ALU_OVR_W-1:0] {
    OVR_NONE     = 2'd0,
    OVR_IMM      = 2'd1,
    OVR_IMM_HIGH = 2'd2
  } alu_ovr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
    logic x;
  } alu_flags_t;

  // Opcodes B..E are the multi-cycle multiply/divide group.
  function automatic logic is_muldiv_op(input logic [ALU_OP_W-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_pipe_iter_muldiv.sv
// alu_iter_muldiv: one-bit-per-cycle shift-add multiplier / restoring divider.
//   start  : load operands (a, b) and begin; is_div selects divide
//   done   : high after WIDTH iterations, held until the next start
//   hi, lo : multiply -> {high half, low half} of a*b
//            divide   -> {remainder, quotient} of a/b
//   Divide by zero falls out naturally: every trial subtract succeeds,
//   giving quotient all ones and remainder a.
module alu_iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic             div_q, div_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    m_d    = m_q;
    div_d  = div_q;
    busy_d = busy_q;
    done_d = done_q;
    cnt_d  = cnt_q;
    // multiply: {hi,lo} holds partial product with the multiplier in lo
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    // divide: hi is the partial remainder, dividend bits shift out of lo
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};
    if (start) begin
      hi_d   = '0;
      lo_d   = is_div ? a : b;
      m_d    = is_div ? b : a;
      div_d  = is_div;
      busy_d = 1'b1;
      done_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (div_q) begin
        if (!div_diff[WIDTH]) begin
          hi_d = div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      m_q    <= m_d;
      div_q  <= div_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake, between register
// read and writeback. One op in flight; result held until out_ready.
//   in_valid/in_ready   : accept a_in, b_in, op, ovr, ovr_imm, carry_in
//   out_valid/out_ready : result + flag_v/c/n/z/x, set_vc, div_zero
//   Ops 0..A and ADC (and any op with an immediate override) complete in
//   one cycle. MUL/MULH/DIVU/REMU take WIDTH+1 cycles when the
//   ALU_MULDIV_EN macro is defined; otherwise they return 0 with Z=1 in
//   one cycle and no iterative hardware is built.
// Reset: synchronous, active-low (rst_n).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       op,
  input  logic [1:0]       ovr,
  input  logic [IMM_W-1:0] ovr_imm,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_v,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_x,
  output logic             set_vc,
  output logic             div_zero
);
  localparam int               MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  function automatic alu_flags_t mk_flags(input logic [WIDTH-1:0] r,
                                          input logic v, input logic c);
    alu_flags_t f;
    f.v = v;
    f.c = c;
    f.n = r[MSB];
    f.z = (r == '0);
    f.x = &r;
    return f;
  endfunction

  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             set_vc_q, set_vc_d, div_zero_q, div_zero_d;
  logic             out_valid_q, out_valid_d;
  logic             fire, ld_sc;

  // single-cycle datapath
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_v, sc_c, sc_set_vc, shift_big;

`ifdef ALU_MULDIV_EN
  alu_state_t       state_q, state_d;
  logic [3:0]       iop_q, iop_d;
  logic             bz_q, bz_d;
  logic             go_iter, it_start, it_done;
  logic [WIDTH-1:0] it_hi, it_lo, iter_res;

  // an override always wins, so B..E with IMM/IMM_HIGH stay single-cycle
  assign go_iter  = is_muldiv_op(op) && (ovr != OVR_IMM) && (ovr != OVR_IMM_HIGH);
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready;
  assign ld_sc    = fire && !go_iter;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (it_start),
    .is_div (is_div_op(op)),
    .a      (a_in),
    .b      (b_in),
    .done   (it_done),
    .hi     (it_hi),
    .lo     (it_lo)
  );
`else
  assign in_ready = !out_valid_q || out_ready;
  assign fire     = in_valid && in_ready;
  assign ld_sc    = fire;
`endif

  always_comb begin
    add_w     = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, (op == OP_ADC) & carry_in};
    sub_w     = {1'b0, a_in} - {1'b0, b_in};
    shift_big = (b_in >= WIDTH_V);
    sc_res    = '0;
    sc_v      = 1'b0;
    sc_c      = 1'b0;
    case (op)
      OP_NOT:  sc_res = ~a_in;
      OP_AND:  sc_res = a_in & b_in;
      OP_OR:   sc_res = a_in | b_in;
      OP_XOR:  sc_res = a_in ^ b_in;
      OP_ADD, OP_ADC: begin
        sc_res = add_w[MSB:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (a_in[MSB] == b_in[MSB]) && (add_w[MSB] != a_in[MSB]);
      end
      OP_SUB, OP_CMP: begin
        sc_res = sub_w[MSB:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = (a_in[MSB] != b_in[MSB]) && (sub_w[MSB] != a_in[MSB]);
      end
      OP_MOV:  sc_res = b_in;
      OP_SHR:  sc_res = shift_big ? '0 : (a_in >> b_in);
      OP_SSHR: sc_res = shift_big ? {WIDTH{a_in[MSB]}} : $unsigned($signed(a_in) >>> b_in);
      OP_SHL:  sc_res = shift_big ? '0 : (a_in << b_in);
      default: sc_res = '0;  // B..E: iterative path, or 0 when not built
    endcase
    case (ovr)
      OVR_IMM: begin
        sc_res = {{(WIDTH-IMM_W){ovr_imm[IMM_W-1]}}, ovr_imm};
        sc_v   = 1'b0;
        sc_c   = 1'b0;
      end
      OVR_IMM_HIGH: begin
        sc_res = WIDTH'({ovr_imm, a_in[IMM_W-1:0]});
        sc_v   = 1'b0;
        sc_c   = 1'b0;
      end
      default: ;
    endcase
    sc_set_vc = is_muldiv_op(op) ? 1'b0 : (op == OP_ADC) ? 1'b1 : op[2];
  end

  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    set_vc_d    = set_vc_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q && !out_ready;
    if (ld_sc) begin
      result_d    = sc_res;
      flags_d     = mk_flags(sc_res, sc_v, sc_c);
      set_vc_d    = sc_set_vc;
      div_zero_d  = 1'b0;
      out_valid_d = 1'b1;
    end
`ifdef ALU_MULDIV_EN
    state_d  = state_q;
    iop_d    = iop_q;
    bz_d     = bz_q;
    it_start = 1'b0;
    iter_res = ((iop_q == OP_MULH) || (iop_q == OP_REMU)) ? it_hi : it_lo;
    case (state_q)
      ST_IDLE: begin
        if (fire && go_iter) begin
          it_start = 1'b1;
          iop_d    = op;
          bz_d     = (b_in == '0);
          state_d  = is_div_op(op) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (it_done) begin
          result_d    = iter_res;
          // multiply reports a nonzero high half on C
          flags_d     = mk_flags(iter_res, 1'b0, (state_q == ST_MUL) && (it_hi != '0));
          set_vc_d    = 1'b0;
          div_zero_d  = (state_q == ST_DIV) && bz_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      flags_q     <= '0;
      set_vc_q    <= 1'b0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      set_vc_q    <= set_vc_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALU_MULDIV_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iop_q   <= '0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      iop_q   <= iop_d;
      bz_q    <= bz_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_v    = flags_q.v;
  assign flag_c    = flags_q.c;
  assign flag_n    = flags_q.n;
  assign flag_z    = flags_q.z;
  assign flag_x    = flags_q.x;
  assign set_vc    = set_vc_q;
  assign div_zero  = div_zero_q;

endmodule
